// File: rtl/microwave_pkg.sv
// Shared state encoding and per-state output patterns for the microwave panel FSM.
// Output patterns are packed as {Start, Close, Heat, Error}.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ERR_OPEN   = 3'd1,
    S_ERR_CLOSED = 3'd2,
    S_CLOSED     = 3'd3,
    S_START      = 3'd4,
    S_COOK       = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  localparam logic [3:0] OUT_IDLE       = 4'b0000;
  localparam logic [3:0] OUT_ERR_OPEN   = 4'b1001;
  localparam logic [3:0] OUT_ERR_CLOSED = 4'b1101;
  localparam logic [3:0] OUT_CLOSED     = 4'b0100;
  localparam logic [3:0] OUT_START      = 4'b1100;
  localparam logic [3:0] OUT_COOK       = 4'b1110;
  localparam logic [3:0] OUT_DONE       = 4'b0100;

  function automatic logic [3:0] state_outputs(input state_t s);
    logic [3:0] v;
    v = OUT_IDLE;
    case (s)
      S_IDLE:       v = OUT_IDLE;
      S_ERR_OPEN:   v = OUT_ERR_OPEN;
      S_ERR_CLOSED: v = OUT_ERR_CLOSED;
      S_CLOSED:     v = OUT_CLOSED;
      S_START:      v = OUT_START;
      S_COOK:       v = OUT_COOK;
      S_DONE:       v = OUT_DONE;
      default:      v = OUT_IDLE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/microwave_cnt.sv
// Clear/enable counter that flags the last of TERMINAL enabled cycles (TERMINAL >= 1).
module microwave_cnt #(
  parameter int unsigned TERMINAL = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == LAST);

endmodule

// File: rtl/microwave_fsm.sv
// Microwave front-panel control FSM (Moore, registered outputs).
// Optional COOK timeout is built only when MICROWAVE_COOK_TIMEOUT_EN is defined.
module microwave_fsm
  import microwave_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES   = 1,
  parameter int unsigned COOK_MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic reset,
  input  logic closeDoor,
  input  logic startOven,
  input  logic done,
  output logic Start,
  output logic Close,
  output logic Heat,
  output logic Error
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_out;
  logic       w_in_start;
  logic       w_in_cook;
  logic       w_warm_tc;
  logic       w_cook_tc;

  assign w_in_start = (r_state == S_START);
  assign w_in_cook  = (r_state == S_COOK);

  // Counter sits at zero outside START, so every START visit lasts WARMUP_CYCLES.
  microwave_cnt #(.TERMINAL(WARMUP_CYCLES)) u_warm_cnt (
    .clk   (clk),
    .i_rst (sys_reset),
    .i_clr (!w_in_start),
    .i_en  (w_in_start),
    .o_tc  (w_warm_tc)
  );

`ifdef MICROWAVE_COOK_TIMEOUT_EN
  microwave_cnt #(.TERMINAL(COOK_MAX_CYCLES)) u_cook_cnt (
    .clk   (clk),
    .i_rst (sys_reset),
    .i_clr (!w_in_cook),
    .i_en  (w_in_cook),
    .o_tc  (w_cook_tc)
  );
`else
  assign w_cook_tc = 1'b0;
  // COOK_MAX_CYCLES stays in the parameter list so timeout builds can override it.
  if (COOK_MAX_CYCLES == 0) begin : g_cook_max_unused
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (closeDoor)      w_next = S_CLOSED;
        else if (startOven) w_next = S_ERR_OPEN;
      end
      S_ERR_OPEN: begin
        if (!closeDoor && reset) w_next = S_IDLE;
        else if (closeDoor)      w_next = S_ERR_CLOSED;
      end
      S_ERR_CLOSED: begin
        if (!closeDoor)  w_next = S_ERR_OPEN;
        else if (reset)  w_next = S_CLOSED;
      end
      S_CLOSED: begin
        if (!closeDoor)     w_next = S_IDLE;
        else if (reset)     w_next = S_CLOSED;
        else if (startOven) w_next = S_START;
      end
      S_START: begin
        if (!closeDoor)     w_next = S_IDLE;
        else if (reset)     w_next = S_CLOSED;
        else if (w_warm_tc) w_next = S_COOK;
      end
      S_COOK: begin
        if (!closeDoor)             w_next = S_IDLE;
        else if (reset)             w_next = S_CLOSED;
        else if (done || w_cook_tc) w_next = S_DONE;
      end
      S_DONE: begin
        if (!closeDoor)      w_next = S_IDLE;
        else if (reset)      w_next = S_CLOSED;
        else if (!startOven) w_next = S_CLOSED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they always equal
  // the decode of r_state without a combinational path to the pins.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= state_outputs(w_next);
    end
  end

  assign {Start, Close, Heat, Error} = r_out;

endmodule

// File: tb/tb_microwave_fsm.sv
// Self-checking bench for microwave_fsm: flag-level behavioural model compared every cycle,
// plus directed scenarios with literal expectations. Honors MICROWAVE_COOK_TIMEOUT_EN.
module tb_microwave_fsm;

  localparam int unsigned WARM = 3;
  localparam int unsigned CMAX = 8;
`ifdef MICROWAVE_COOK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_reset, reset, closeDoor, startOven, done;
  logic Start, Close, Heat, Error;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  microwave_fsm #(.WARMUP_CYCLES(WARM), .COOK_MAX_CYCLES(CMAX)) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .reset     (reset),
    .closeDoor (closeDoor),
    .startOven (startOven),
    .done      (done),
    .Start     (Start),
    .Close     (Close),
    .Heat      (Heat),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  // Model expressed as oven facts: door latched closed, error pending,
  // warmup cycles remaining, cooking (with elapsed time), finished awaiting release.
  bit m_door, m_err, m_cook, m_fin;
  int m_warm, m_cook_t;

  function automatic logic [3:0] m_exp();
    return {(m_err || (m_warm > 0) || m_cook), m_door, m_cook, m_err};
  endfunction

  always @(posedge clk) begin
    if (sys_reset) begin
      m_door = 0; m_err = 0; m_cook = 0; m_fin = 0; m_warm = 0; m_cook_t = 0;
    end else if (m_err) begin
      if (closeDoor) begin
        if (m_door && reset) m_err = 0;
        m_door = 1;
      end else begin
        if (!m_door && reset) m_err = 0;
        m_door = 0;
      end
    end else if (!m_door) begin
      if (closeDoor)      m_door = 1;
      else if (startOven) m_err = 1;
    end else if (!closeDoor) begin
      m_door = 0; m_cook = 0; m_fin = 0; m_warm = 0;
    end else if (reset) begin
      m_cook = 0; m_fin = 0; m_warm = 0;
    end else if (m_fin) begin
      if (!startOven) m_fin = 0;
    end else if (m_cook) begin
      m_cook_t++;
      if (done || (TO_EN && m_cook_t == CMAX)) begin
        m_cook = 0; m_fin = 1;
      end
    end else if (m_warm > 0) begin
      m_warm--;
      if (m_warm == 0) begin
        m_cook = 1; m_cook_t = 0;
      end
    end else if (startOven) begin
      m_warm = WARM;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({Start, Close, Heat, Error} !== m_exp()) begin
        errors++;
        $display("FAIL model t=%0t got=%b exp=%b", $time, {Start, Close, Heat, Error}, m_exp());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] exp);
    checks++;
    if ({Start, Close, Heat, Error} !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, {Start, Close, Heat, Error}, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic c, input logic s, input logic d);
    reset = r; closeDoor = c; startOven = s; done = d;
  endtask

  int heat_n;

  initial begin
    sys_reset = 1'b1;
    set_in(0, 0, 0, 0);
    tick(2);
    sys_reset = 1'b0;
    chk_en = 1'b1;

    // 1: reset state held
    tick(3);                 lit("idle", 4'b0000);

    // 2: normal cook cycle
    set_in(0, 1, 0, 0); tick(1); lit("closed", 4'b0100);
    set_in(0, 1, 1, 0); tick(1); lit("start", 4'b1100);
    tick(WARM - 1);          lit("warm_last", 4'b1100);
    tick(1);                 lit("cook", 4'b1110);
    set_in(0, 1, 1, 1); tick(1); lit("done", 4'b0100);
    set_in(0, 1, 1, 0); tick(3); lit("done_held", 4'b0100);
    set_in(0, 1, 0, 0); tick(1); lit("release", 4'b0100);

    // 3: error path
    set_in(0, 0, 0, 0); tick(1); lit("open", 4'b0000);
    set_in(0, 0, 1, 0); tick(1); lit("err_open", 4'b1001);
    set_in(0, 0, 0, 0); tick(2); lit("err_sticky", 4'b1001);
    set_in(0, 1, 1, 0); tick(1); lit("err_closed", 4'b1101);
    tick(2);                 lit("err_ign_start", 4'b1101);
    set_in(1, 1, 0, 0); tick(1); lit("err_reset", 4'b0100);
    set_in(0, 1, 1, 0); tick(1); lit("restart", 4'b1100);
    tick(WARM);              lit("recook", 4'b1110);

    // 4: door opens while done also asserted
    set_in(0, 0, 1, 1); tick(1); lit("door_safety", 4'b0000);
    set_in(0, 0, 0, 0); tick(1);

    // 5: user reset during cook, start held through release
    set_in(0, 1, 0, 0); tick(1);
    set_in(0, 1, 1, 0); tick(1 + WARM); lit("cook5", 4'b1110);
    set_in(1, 1, 1, 0); tick(1); lit("user_reset", 4'b0100);
    tick(1);                 lit("reset_hold", 4'b0100);
    set_in(0, 1, 1, 0); tick(1); lit("start_again", 4'b1100);

    // reset from ERR_OPEN with door open
    set_in(0, 0, 1, 0); tick(1); lit("abort_open", 4'b0000);
    tick(1);                 lit("err_open2", 4'b1001);
    set_in(1, 0, 0, 0); tick(1); lit("err_open_reset", 4'b0000);

    // sys_reset overrides everything mid-cook
    set_in(0, 1, 0, 0); tick(1);
    set_in(0, 1, 1, 0); tick(1 + WARM); lit("cook_sr", 4'b1110);
    sys_reset = 1'b1; set_in(1, 1, 1, 1); tick(1); lit("sys_reset", 4'b0000);
    sys_reset = 1'b0; set_in(0, 0, 0, 0); tick(1);

    // 6: cook timeout (or its absence), bounded loop
    set_in(0, 1, 0, 0); tick(1);
    set_in(0, 1, 1, 0); tick(1 + WARM); lit("cook6", 4'b1110);
    heat_n = 1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (Heat !== 1'b1) break;
      heat_n++;
    end
    checks++;
    if (heat_n != (TO_EN ? CMAX : 31)) begin
      errors++;
      $display("FAIL heat_cycles got=%0d exp=%0d", heat_n, (TO_EN ? CMAX : 31));
    end
    if (TO_EN) lit("timeout_done", 4'b0100);
    else       lit("no_timeout", 4'b1110);

    set_in(0, 0, 0, 0); tick(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
